// File: rtl/override_pkg.sv
// override_pkg: opcode/state encodings and default hold-count width for override_seq
package override_pkg;
    localparam int HOLD_W_DEF = 8;
    typedef enum logic [1:0] {OP_NOP, OP_CLEAR, OP_PRESET, OP_ILL} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_e;
endpackage

// File: rtl/override_seq.sv
// override_seq: sequences timed active-low clear/preset overrides to a target flop
module override_seq
    import override_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic              clear,
    output logic              preset,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_e state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic tgt_clr_q, tgt_clr_d;
    logic clear_q, clear_d, preset_q, preset_d, busy_q, busy_d;
    logic done_q, done_d, err_q, err_d, ready_q, ready_d;
    op_e op;
    logic accept;
    assign op = op_e'(cmd_op);
    assign accept = cmd_valid && ready_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        tgt_clr_d = tgt_clr_q;
        err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && (op == OP_CLEAR || op == OP_PRESET)) begin
                    state_d = S_ASSERT;
                    cnt_d = cmd_hold;
                    tgt_clr_d = (op == OP_CLEAR);
                end
                err_d = accept && (op == OP_ILL);
            end
            S_ASSERT: begin
                state_d = (abort || cnt_q == '0) ? S_GAP : S_ASSERT;
                cnt_d = (abort || cnt_q == '0) ? '0 : cnt_q - HOLD_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // outputs are precomputed from the next state so every port is a flop
        clear_d = !(state_d == S_ASSERT && tgt_clr_d);
        preset_d = !(state_d == S_ASSERT && !tgt_clr_d);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_GAP);
        ready_d = (state_d == S_IDLE);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            tgt_clr_q <= 1'b0;
            clear_q <= 1'b1;
            preset_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            tgt_clr_q <= tgt_clr_d;
            clear_q <= clear_d;
            preset_q <= preset_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            ready_q <= ready_d;
        end
    end
    assign clear = clear_q;
    assign preset = preset_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign cmd_ready = ready_q;
endmodule

// File: tb/tb_override_seq.sv
// tb_override_seq: directed and randomized checks of override_seq against a queue-based trace model
module tb_override_seq;
    import override_pkg::*;
    localparam int HW = 8;
    typedef logic [5:0] exp_t;
    localparam exp_t RST_E = 6'b110000;
    localparam exp_t IDLE_E = 6'b110001;
    localparam exp_t ERR_E = 6'b110011;
    localparam exp_t CLR_E = 6'b011000;
    localparam exp_t PRE_E = 6'b101000;
    localparam exp_t GAP_E = 6'b111100;
    logic clock = 1'b0;
    logic reset, cmd_valid, abort, cmd_ready, clear, preset, busy, done, err;
    logic [1:0] cmd_op;
    logic [HW-1:0] cmd_hold;
    int total = 0;
    int bad = 0;
    exp_t cur = RST_E;
    exp_t q[$];
    always #5 clock = ~clock;
    override_seq #(.HOLD_W(HW)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_hold(cmd_hold), .abort(abort), .clear(clear),
        .preset(preset), .busy(busy), .done(done), .err(err)
    );
    function automatic exp_t obs();
        return {clear, preset, busy, done, err, cmd_ready};
    endfunction
    task automatic drive(input logic v, input logic [1:0] op, input logic [HW-1:0] h,
                         input logic ab, input logic rs);
        cmd_valid = v;
        cmd_op = op;
        cmd_hold = h;
        abort = ab;
        reset = rs;
    endtask
    // Model: an accepted command expands into its full expected output trace.
    task automatic tick();
        logic ill;
        @(posedge clock);
        ill = 1'b0;
        if (reset) begin
            q.delete();
            cur = RST_E;
        end else begin
            if (abort && cur[3] && !cur[2])
                while (q.size() > 0 && !q[0][2]) q.delete(0);
            if (cmd_valid && cur[0]) begin
                if (cmd_op == 2'd1 || cmd_op == 2'd2) begin
                    repeat (int'(cmd_hold) + 1) q.push_back(cmd_op == 2'd1 ? CLR_E : PRE_E);
                    q.push_back(GAP_E);
                end
                ill = (cmd_op == 2'd3);
            end
            cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
            if (ill) cur[1] = 1'b1;
        end
        @(negedge clock);
    endtask
    task automatic test_reset();
        drive(1, 2'd1, 8'd3, 1, 1);
        tick();
        total++;
        if (obs() !== RST_E) begin bad++; $display("FAIL reset_state got=%b exp=%b", obs(), RST_E); end
        drive(0, 0, 0, 0, 0);
        tick();
        total++;
        if (obs() !== IDLE_E) begin bad++; $display("FAIL post_reset_idle got=%b exp=%b", obs(), IDLE_E); end
    endtask
    task automatic test_clear_hold3();
        exp_t e;
        drive(1, 2'd1, 8'd3, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            e = (i <= 4) ? CLR_E : (i == 5) ? GAP_E : IDLE_E;
            total++;
            if (obs() !== e) begin bad++; $display("FAIL clear_hold3 cyc=%0d got=%b exp=%b", i, obs(), e); end
            tick();
        end
    endtask
    task automatic test_preset_hold0();
        drive(1, 2'd2, 8'd0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        total++;
        if (obs() !== PRE_E) begin bad++; $display("FAIL preset_hold0_assert got=%b exp=%b", obs(), PRE_E); end
        tick();
        total++;
        if (obs() !== GAP_E) begin bad++; $display("FAIL preset_hold0_gap got=%b exp=%b", obs(), GAP_E); end
        tick();
    endtask
    task automatic test_abort();
        drive(0, 0, 0, 1, 0);
        tick();
        total++;
        if (obs() !== IDLE_E) begin bad++; $display("FAIL abort_idle_ignored got=%b exp=%b", obs(), IDLE_E); end
        drive(1, 2'd1, 8'd10, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            total++;
            if (obs() !== CLR_E) begin bad++; $display("FAIL abort_assert cyc=%0d got=%b exp=%b", i, obs(), CLR_E); end
            if (i == 3) abort = 1'b1;
            tick();
        end
        abort = 1'b1;
        total++;
        if (obs() !== GAP_E) begin bad++; $display("FAIL abort_gap got=%b exp=%b", obs(), GAP_E); end
        tick();
        abort = 1'b0;
        total++;
        if (obs() !== IDLE_E) begin bad++; $display("FAIL abort_back_idle got=%b exp=%b", obs(), IDLE_E); end
    endtask
    task automatic test_illegal_nop();
        int errs = 0;
        int dones = 0;
        drive(1, 2'd3, 8'd4, 0, 0);
        tick();
        total++;
        if (obs() !== ERR_E) begin bad++; $display("FAIL illegal_err got=%b exp=%b", obs(), ERR_E); end
        drive(1, 2'd0, 8'd4, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        total++;
        if (obs() !== IDLE_E) begin bad++; $display("FAIL nop_idle got=%b exp=%b", obs(), IDLE_E); end
        for (int i = 0; i < 4; i++) begin
            errs += int'(err);
            dones += int'(done);
            tick();
        end
        total++;
        if (errs != 0 || dones != 0) begin bad++; $display("FAIL nop_no_pulse err=%0d done=%0d exp=0/0", errs, dones); end
    endtask
    task automatic test_reset_mid();
        int dones = 0;
        drive(1, 2'd2, 8'd5, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        total++;
        if (obs() !== PRE_E) begin bad++; $display("FAIL reset_mid_assert got=%b exp=%b", obs(), PRE_E); end
        drive(1, 2'd1, 8'd2, 1, 1);
        tick();
        total++;
        if (obs() !== RST_E) begin bad++; $display("FAIL reset_mid_release got=%b exp=%b", obs(), RST_E); end
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            dones += int'(done);
        end
        total++;
        if (dones != 0 || obs() !== IDLE_E) begin
            bad++;
            $display("FAIL reset_mid_no_done done=%0d got=%b exp=%b", dones, obs(), IDLE_E);
        end
    endtask
    task automatic test_back_to_back();
        exp_t seq [8] = '{CLR_E, CLR_E, CLR_E, GAP_E, IDLE_E, PRE_E, PRE_E, GAP_E};
        drive(1, 2'd1, 8'd2, 0, 0);
        tick();
        drive(1, 2'd2, 8'd1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (obs() !== seq[i] || (!clear && !preset)) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i + 1, obs(), seq[i]);
            end
            if (i == 5) cmd_valid = 1'b0;
            tick();
        end
    endtask
    task automatic test_max_hold();
        int low = 0;
        int n = 0;
        drive(1, 2'd1, 8'hff, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        while (!done && n < 300) begin
            low += int'(!clear);
            n++;
            tick();
        end
        total++;
        if (!done || low != 256) begin bad++; $display("FAIL max_hold low_cycles=%0d exp=256 done=%b", low, done); end
        tick();
    endtask
    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), HW'($urandom_range(0, 6)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
            tick();
            if (obs() !== cur || (!clear && !preset)) begin
                errs++;
                if (errs <= 5) $display("FAIL random cyc=%0d got=%b exp=%b", i, obs(), cur);
            end
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL random_total mismatching_cycles=%0d exp=0", errs); end
    endtask
    initial begin
        drive(0, 0, 0, 0, 1);
        @(negedge clock);
        test_reset();
        test_clear_hold3();
        test_preset_hold0();
        test_abort();
        test_illegal_nop();
        test_reset_mid();
        test_back_to_back();
        test_max_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/override_seq.md
OVERRIDE_SEQ -- requirements
Module: override_seq

Interface
REQ-001 Parameter HOLD_W, default 8, SHALL set the width of the hold-count field.
REQ-002 Port clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port cmd_valid  input  1  SHALL indicate that a command is offered.
REQ-005 Port cmd_ready  output  1  SHALL indicate that a command can be accepted.
REQ-006 Port cmd_op  input  2  SHALL carry the opcode: 00 NOP, 01 CLEAR, 10 PRESET, 11 illegal.
REQ-007 Port cmd_hold  input  HOLD_W  SHALL carry the hold count; assertion length is cmd_hold+1 cycles.
REQ-008 Port abort  input  1  SHALL request early termination of an active assertion.
REQ-009 Port clear  output  1  SHALL be the active-low clear override to the target flop.
REQ-010 Port preset  output  1  SHALL be the active-low preset override to the target flop.
REQ-011 Port busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 Port done  output  1  SHALL be a one-cycle pulse at the end of each CLEAR or PRESET sequence.
REQ-013 Port err  output  1  SHALL be a one-cycle pulse when an illegal opcode is accepted.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ASSERT and GAP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid and cmd_ready both high.
REQ-016 Accepted CLEAR/PRESET: load hold counter with cmd_hold, go to ASSERT; the selected output goes low from the next cycle (latency 1).
REQ-017 In ASSERT, the counter SHALL decrement each cycle; at count 0 the next state SHALL be GAP (output low for exactly cmd_hold+1 cycles).
REQ-018 In ASSERT, abort=1 SHALL force GAP on the next edge regardless of count; an abort in IDLE or GAP SHALL be ignored.
REQ-019 In GAP, clear and preset SHALL both be 1, done SHALL be 1 for that single cycle, and the next state SHALL be IDLE (one guard cycle, no back-to-back overrides).
REQ-020 Accepted NOP SHALL stay in IDLE with no output change and no done pulse.
REQ-021 Accepted illegal opcode (11) SHALL stay in IDLE and pulse err on the next cycle with no output change.
REQ-022 clear and preset SHALL never be low simultaneously in any cycle.
REQ-023 cmd_hold at the maximum value (2^HOLD_W-1) SHALL give 2^HOLD_W assertion cycles, with no counter wrap.
REQ-024 Command inputs presented while cmd_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-025 All outputs SHALL be driven from registers, with no combinational path from inputs to clear or preset.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, clear=1, preset=1, busy=0, done=0, err=0, counter=0, and cmd_ready=0 for that cycle.
REQ-027 Reset during ASSERT SHALL release the override on the next edge without a done pulse.
REQ-028 reset SHALL take priority over abort and cmd_valid.

Structure
REQ-029 Package override_pkg SHALL hold the opcode enum, the state enum and the HOLD_W default.
REQ-030 The block SHALL be a single module with no sub-module; the hold counter is inline.

Verification
REQ-031 CLEAR, hold=3 -> clear low cycles 1-4 after accept, done in cycle 5, cmd_ready in cycle 6.
REQ-032 PRESET, hold=0 -> preset low for exactly 1 cycle, then GAP with done=1.
REQ-033 CLEAR, hold=10, abort at the 3rd ASSERT cycle -> clear low for 3 cycles, then done.
REQ-034 Op 11, then op 00 -> err pulses once, clear/preset stay 1, and no done pulse occurs.
REQ-035 PRESET, hold=5, reset at the 2nd ASSERT cycle -> preset=1 on the next edge, busy=0, and no done pulse.
REQ-036 Back-to-back CLEAR then PRESET with cmd_valid held -> at least one GAP cycle between them, and clear and preset are never low together.
